lane_gene_collector: RTL and testbench
======================================

// Module: lane_gene_collector
// PURPOSE
//  Downstream end of the mutation lane's two-gene output interface.
//  Accepts up to two genes per cycle (gene_in1/gene_in2 qualified by in_valid[1:0]).
//  Buffers them in order in a FIFO and presents one gene per cycle to the genome-memory writer over valid/ready.
//  Signals done when the lane stops issuing and all buffered genes have been taken.
// PARAMETERS
//  GENE_SZ  64  gene width in bits
//  ATTR_SZ  8   attribute field width (gene_count width is 2*ATTR_SZ)
//  DEPTH    8   FIFO entries, power of two, >= 2
//  PTR_SZ   3   log2(DEPTH)
// PORTS
//  clk         in   1            clock, rising edge
//  rst         in   1            reset, asynchronous, active-low
//  state       in   2            lane state; 2'b00 and 2'b10 = active, others = idle
//  gene_in1    in   GENE_SZ      first gene from lane
//  gene_in2    in   GENE_SZ      second (inserted) gene from lane
//  in_valid    in   2            bit0 qualifies gene_in1, bit1 qualifies gene_in2
//  gene_out    out  GENE_SZ      gene to memory writer, registered
//  out_valid   out  1            gene_out valid
//  out_ready   in   1            writer accepts gene_out this cycle
//  fifo_count  out  PTR_SZ+1     entries held, including the output register
//  gene_count  out  2*ATTR_SZ    genes handed off since last IDLE->COLLECT, wraps
//  overflow    out  1            sticky: a valid input gene was dropped
//  busy        out  1            FSM not in IDLE
//  done        out  1            one-cycle pulse when drain completes
// BEHAVIOUR
//  - Reset (rst=0, any time, async): all outputs 0; FIFO emptied; FSM to IDLE. Reset mid-drain discards buffered genes.
//  - Capture: inputs are sampled only when state is active and the FSM is IDLE or COLLECT.
//    Push order: gene_in1 before gene_in2.
//    in_valid=2'b10 pushes gene_in2 only. 2'b00 pushes nothing.
//  - Space: free = DEPTH - fifo_count + (out_valid & out_ready).
//    A pop in the same cycle frees a slot for that cycle's pushes.
//  - Overflow: if the number of valid inputs > free, gene_in1 is kept when free=1.
//    Excess genes are dropped and overflow is set. overflow is cleared only by reset or on IDLE->COLLECT.
//  - Output: first-word-fall-through.
//    A gene pushed into an empty FIFO gives out_valid=1 on the next cycle.
//    gene_out and out_valid hold stable while out_valid & ~out_ready.
//    On handshake (out_valid & out_ready), the next entry is loaded the same edge; otherwise out_valid goes to 0.
//  - gene_count increments by 1 on each handshake, mod 2^(2*ATTR_SZ).
//  - FSM:
//    IDLE    -> COLLECT when state active; clears gene_count and overflow; same-cycle inputs are captured.
//    COLLECT -> DRAIN when state becomes non-active; inputs are ignored from that cycle on.
//    DRAIN   -> DONE when fifo_count==0, including the case where the last pop happens this cycle.
//    DONE    -> IDLE unconditionally. done=1 only while in DONE.
//    A return to active state during DRAIN is ignored until IDLE.
//  - If state leaves active with the FIFO already empty: COLLECT->DRAIN->DONE->IDLE, so done rises 2 cycles later.
//  - busy=1 in COLLECT, DRAIN and DONE.
// TESTING
//  - Reset: rst=0 with random inputs -> gene_out=0, out_valid=0, fifo_count=0, done=0, busy=0.
//  - Ordering: state=10, 3 cycles in_valid=11 with pairs (A,B), (C,D), (E,F), out_ready=1
//    -> out_valid rises 1 cycle after first capture; genes leave as A,B,C,D,E,F; gene_count=6.
//  - Backpressure: out_ready=0, push 8 genes -> fifo_count=8, gene_out stable.
//    Then push in_valid=11 (G,H) -> both dropped, overflow=1.
//    Repeat with out_ready=1 -> G kept, H dropped.
//  - Single-slot rule: fifo_count=7, out_ready=0, in_valid=11 (X,Y) -> X stored, Y dropped, overflow=1, fifo_count=8.
//  - Drain/done: 4 genes buffered, state->11, out_ready=1 -> 4 handshakes, one done pulse, busy=0 next cycle.
//    Inputs with in_valid=11 during the drain are not stored.
//  - Async reset mid-drain: rst=0 between clock edges with fifo_count=5 -> outputs 0 immediately.
//    After release, state=00 starts a fresh COLLECT with gene_count=0.

Source files
------------

// File: rtl/lane_gene_collector_if.sv
// Two-gene lane input bus plus the one-gene valid/ready bus toward the genome-memory writer.
// The slave side is the collector; the master side is the lane and the writer together.
interface lane_gene_collector_if #(
  parameter int unsigned GENE_SZ = 64
);
  logic [1:0]         state;
  logic [GENE_SZ-1:0] gene_in1;
  logic [GENE_SZ-1:0] gene_in2;
  logic [1:0]         in_valid;
  logic [GENE_SZ-1:0] gene_out;
  logic               out_valid;
  logic               out_ready;

  modport master (
    output state, gene_in1, gene_in2, in_valid, out_ready,
    input  gene_out, out_valid
  );

  modport slave (
    input  state, gene_in1, gene_in2, in_valid, out_ready,
    output gene_out, out_valid
  );
endinterface

// File: rtl/lane_gene_collector.sv
// Buffers up to two genes per cycle from the mutation lane in a FWFT FIFO and hands them
// one at a time to the genome-memory writer; pulses done once the lane stops and the FIFO drains.
module lane_gene_collector #(
  parameter int unsigned GENE_SZ = 64,
  parameter int unsigned ATTR_SZ = 8,
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned PTR_SZ  = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  lane_gene_collector_if.slave   bus,
  output logic [PTR_SZ:0]        fifo_count,
  output logic [2*ATTR_SZ-1:0]   gene_count,
  output logic                   overflow,
  output logic                   busy,
  output logic                   done
);

  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StCollect = 2'd1;
  localparam logic [1:0] StDrain   = 2'd2;
  localparam logic [1:0] StDone    = 2'd3;
  localparam int unsigned CW = PTR_SZ + 2;

  logic [1:0]           fsm_q, fsm_d;
  logic [GENE_SZ-1:0]   mem_q [DEPTH];
  logic [PTR_SZ-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, wr_ptr_nxt;
  logic [PTR_SZ:0]      count_q, count_d, mem_count;
  logic [GENE_SZ-1:0]   out_q, out_d;
  logic                 out_valid_q, out_valid_d;
  logic [2*ATTR_SZ-1:0] gene_count_q, gene_count_d;
  logic                 overflow_q, overflow_d;

  logic                 active, capture, start, pop, drop;
  logic [CW-1:0]        free;
  logic [1:0]           n_push, n_valid, n_mem;
  logic [GENE_SZ-1:0]   p0, p1, m0, m1;

  assign active     = (bus.state == 2'b00) || (bus.state == 2'b10);
  assign capture    = active && ((fsm_q == StIdle) || (fsm_q == StCollect));
  assign start      = active && (fsm_q == StIdle);
  assign pop        = out_valid_q && bus.out_ready;
  // A same-cycle pop frees a slot for this cycle's pushes.
  assign free       = CW'(DEPTH) - CW'(count_q) + CW'(pop);
  assign mem_count  = count_q - (PTR_SZ+1)'(out_valid_q);
  assign wr_ptr_nxt = wr_ptr_q + PTR_SZ'(1);

  // Select accepted genes in lane order; gene_in1 wins the last free slot.
  always_comb begin
    n_push  = 2'd0;
    p0      = bus.gene_in1;
    p1      = bus.gene_in2;
    n_valid = capture ? ({1'b0, bus.in_valid[0]} + {1'b0, bus.in_valid[1]}) : 2'd0;
    if (capture) begin
      case (bus.in_valid)
        2'b01: if (free != '0) n_push = 2'd1;
        2'b10: begin
          p0 = bus.gene_in2;
          if (free != '0) n_push = 2'd1;
        end
        2'b11: begin
          if (free >= CW'(2))    n_push = 2'd2;
          else if (free != '0)   n_push = 2'd1;
        end
        default: ;
      endcase
    end
    drop = (n_push < n_valid);
  end

  // Refill the output register from storage first, else bypass the oldest new push.
  always_comb begin
    out_d       = out_q;
    out_valid_d = out_valid_q;
    rd_ptr_d    = rd_ptr_q;
    m0          = p0;
    m1          = p1;
    n_mem       = n_push;
    if (!out_valid_q || pop) begin
      if (mem_count != '0) begin
        out_d       = mem_q[rd_ptr_q];
        out_valid_d = 1'b1;
        rd_ptr_d    = rd_ptr_q + PTR_SZ'(1);
      end else if (n_push != 2'd0) begin
        out_d       = p0;
        out_valid_d = 1'b1;
        m0          = p1;
        n_mem       = n_push - 2'd1;
      end else begin
        out_valid_d = 1'b0;
      end
    end
    wr_ptr_d = wr_ptr_q + PTR_SZ'(n_mem);
    count_d  = count_q + (PTR_SZ+1)'(n_push) - (PTR_SZ+1)'(pop);
  end

  always_comb begin
    fsm_d = fsm_q;
    case (fsm_q)
      StIdle:    if (active) fsm_d = StCollect;
      StCollect: if (!active) fsm_d = StDrain;
      StDrain:   if (count_d == '0) fsm_d = StDone;
      StDone:    fsm_d = StIdle;
      default:   fsm_d = StIdle;
    endcase
    gene_count_d = (start ? '0 : gene_count_q) + (2*ATTR_SZ)'(pop);
    overflow_d   = (overflow_q && !start) || drop;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fsm_q        <= StIdle;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      out_q        <= '0;
      out_valid_q  <= 1'b0;
      gene_count_q <= '0;
      overflow_q   <= 1'b0;
    end else begin
      fsm_q        <= fsm_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      out_q        <= out_d;
      out_valid_q  <= out_valid_d;
      gene_count_q <= gene_count_d;
      overflow_q   <= overflow_d;
    end
  end

  // Storage contents need no reset; pointers and count define what is live.
  always_ff @(posedge clk) begin
    if (n_mem != 2'd0) mem_q[wr_ptr_q]   <= m0;
    if (n_mem == 2'd2) mem_q[wr_ptr_nxt] <= m1;
  end

  assign bus.gene_out  = out_q;
  assign bus.out_valid = out_valid_q;
  assign fifo_count    = count_q;
  assign gene_count    = gene_count_q;
  assign overflow      = overflow_q;
  assign busy          = (fsm_q != StIdle);
  assign done          = (fsm_q == StDone);

endmodule

// File: tb/tb_lane_gene_collector.sv
// Scoreboard bench: stimulus queues expected genes, a negedge monitor checks every handshake.
module tb_lane_gene_collector;
  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  fifo_count;
  logic [15:0] gene_count;
  logic        overflow, busy, done;

  always #5 clk = ~clk;

  lane_gene_collector_if #(.GENE_SZ(64)) bus ();

  lane_gene_collector #(
    .GENE_SZ(64), .ATTR_SZ(8), .DEPTH(8), .PTR_SZ(3)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus.slave),
    .fifo_count (fifo_count),
    .gene_count (gene_count),
    .overflow   (overflow),
    .busy       (busy),
    .done       (done)
  );

  int n_pass = 0;
  int n_total = 0;
  int hs_cnt = 0;
  logic [63:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Monitor: every handshake must match the oldest expected gene.
  always @(negedge clk) begin
    if (rst === 1'b1 && bus.out_valid && bus.out_ready) begin
      hs_cnt++;
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL extra_gene: got %0h expected none", bus.gene_out);
      end else begin
        check("gene_order", bus.gene_out, exp_q.pop_front());
      end
    end
  end

  task automatic step(input logic [1:0] st, input logic [1:0] v, input logic [63:0] a,
                      input logic [63:0] b, input logic rdy);
    bus.state     = st;
    bus.in_valid  = v;
    bus.gene_in1  = a;
    bus.gene_in2  = b;
    bus.out_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input logic [1:0] st, input int max);
    int i;
    for (i = 0; i < max && fifo_count != 0; i++) step(st, 2'b00, '0, '0, 1'b1);
    if (fifo_count != 0) begin
      n_total++;
      $display("FAIL drain_timeout: fifo_count %0d expected 0", fifo_count);
    end
  endtask

  task automatic to_idle();
    for (int i = 0; i < 10 && busy; i++) step(2'b11, 2'b00, '0, '0, 1'b1);
    check("to_idle_busy", busy, 0);
  endtask

  initial begin
    logic [63:0] g [16];
    int hs0, done_pulses, done_idx;
    logic prev_done;

    for (int i = 0; i < 16; i++) g[i] = 64'hA5A5_0000_0000_0000 | 64'(i + 1);

    // Reset with random inputs
    rst = 1'b0;
    bus.state     = 2'($urandom);
    bus.in_valid  = 2'($urandom);
    bus.gene_in1  = {$urandom, $urandom};
    bus.gene_in2  = {$urandom, $urandom};
    bus.out_ready = 1'($urandom);
    #12;
    check("rst_gene_out", bus.gene_out, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_fifo_count", fifo_count, 0);
    check("rst_done", done, 0);
    check("rst_busy", busy, 0);
    check("rst_overflow", overflow, 0);
    check("rst_gene_count", gene_count, 0);
    bus.state = 2'b11; bus.in_valid = 2'b00; bus.out_ready = 1'b1;
    #4 rst = 1'b1;
    @(posedge clk); #1;

    // Ordering: A..F in three pair cycles
    check("out_valid_before", bus.out_valid, 0);
    exp_q.push_back(g[0]); exp_q.push_back(g[1]);
    step(2'b10, 2'b11, g[0], g[1], 1'b1);
    check("out_valid_rise", bus.out_valid, 1);
    check("busy_collect", busy, 1);
    exp_q.push_back(g[2]); exp_q.push_back(g[3]);
    step(2'b10, 2'b11, g[2], g[3], 1'b1);
    exp_q.push_back(g[4]); exp_q.push_back(g[5]);
    step(2'b10, 2'b11, g[4], g[5], 1'b1);
    check("count_after_pairs", fifo_count, 4);
    drain(2'b10, 20);
    check("gene_count_order", gene_count, 6);
    to_idle();

    // Backpressure: fill, then full drop, then pop frees one slot
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(g[2*i]); exp_q.push_back(g[2*i+1]);
      step(2'b10, 2'b11, g[2*i], g[2*i+1], 1'b0);
    end
    check("bp_full_count", fifo_count, 8);
    check("bp_gene_stable", bus.gene_out, g[0]);
    check("bp_overflow_clear", overflow, 0);
    step(2'b10, 2'b11, g[8], g[9], 1'b0);
    check("bp_drop_count", fifo_count, 8);
    check("bp_drop_overflow", overflow, 1);
    check("bp_hold_gene", bus.gene_out, g[0]);
    check("bp_hold_valid", bus.out_valid, 1);
    exp_q.push_back(g[10]);
    step(2'b10, 2'b11, g[10], g[11], 1'b1);
    check("bp_pop_push_count", fifo_count, 8);
    check("bp_overflow_sticky", overflow, 1);
    drain(2'b10, 30);
    check("bp_gene_count", gene_count, 9);
    to_idle();

    // Single-slot rule at fifo_count=7
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(g[2*i]); exp_q.push_back(g[2*i+1]);
      step(2'b10, 2'b11, g[2*i], g[2*i+1], 1'b0);
    end
    exp_q.push_back(g[6]);
    step(2'b10, 2'b01, g[6], g[15], 1'b0);
    check("ss_count7", fifo_count, 7);
    check("ss_overflow_cleared", overflow, 0);
    exp_q.push_back(g[12]);
    step(2'b10, 2'b11, g[12], g[13], 1'b0);
    check("ss_count8", fifo_count, 8);
    check("ss_overflow", overflow, 1);
    drain(2'b10, 30);
    to_idle();

    // Drain/done with junk inputs while draining
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back(g[2*i+3]); exp_q.push_back(g[2*i+4]);
      step(2'b00, 2'b11, g[2*i+3], g[2*i+4], 1'b0);
    end
    check("dd_count4", fifo_count, 4);
    hs0 = hs_cnt; done_pulses = 0; done_idx = -1; prev_done = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(2'b11, 2'b11, 64'hDEAD_0000_0000_0000 | 64'(i), 64'hBEEF, 1'b1);
      if (prev_done) check("dd_busy_after_done", busy, 0);
      if (done) begin done_pulses++; done_idx = i; end
      prev_done = done;
    end
    check("dd_handshakes", 64'(hs_cnt - hs0), 4);
    check("dd_done_pulses", 64'(done_pulses), 1);
    check("dd_done_cycle", 64'(done_idx), 3);
    check("dd_fifo_empty", fifo_count, 0);
    check("dd_gene_count", gene_count, 4);

    // Async reset mid-drain
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back(g[2*i+7]); exp_q.push_back(g[2*i+8]);
      step(2'b00, 2'b11, g[2*i+7], g[2*i+8], 1'b0);
    end
    exp_q.push_back(g[14]);
    step(2'b00, 2'b01, g[14], g[0], 1'b0);
    check("ar_count5", fifo_count, 5);
    step(2'b11, 2'b00, '0, '0, 1'b0);
    check("ar_busy_drain", busy, 1);
    #2 rst = 1'b0;
    #1;
    check("ar_fifo_count", fifo_count, 0);
    check("ar_out_valid", bus.out_valid, 0);
    check("ar_gene_out", bus.gene_out, 0);
    check("ar_busy", busy, 0);
    check("ar_gene_count", gene_count, 0);
    exp_q.delete();
    @(posedge clk); #2;
    rst = 1'b1;
    @(posedge clk); #1;
    exp_q.push_back(g[15]);
    step(2'b00, 2'b01, g[15], g[1], 1'b1);
    check("ar_fresh_busy", busy, 1);
    check("ar_fresh_valid", bus.out_valid, 1);
    check("ar_fresh_count0", gene_count, 0);
    step(2'b00, 2'b00, '0, '0, 1'b1);
    check("ar_fresh_count1", gene_count, 1);
    to_idle();
    check("scoreboard_empty", 64'(exp_q.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
